// File: rtl/beta_acs_engine_if.sv
// ---------------------------------------------------------------------------
// beta_acs_engine_if
// Gamma (branch-metric) stream between the LLR front end and the beta
// backward-recursion engine. One vector carries all 16 gammas of a trellis
// step.
//   g_valid : producer has a gamma vector on g_data
//   g_ready : engine accepts a vector this cycle
//   g_data  : slice [(2s+u)*GW +: GW] = g(s,u), s = 0..7, u = 0..1
// master = gamma producer, slave = beta engine.
// ---------------------------------------------------------------------------
interface beta_acs_engine_if #(
    parameter int GW = 16
) ();
    logic              g_valid;
    logic              g_ready;
    logic [16*GW-1:0]  g_data;

    modport master (
        output g_valid,
        output g_data,
        input  g_ready
    );

    modport slave (
        input  g_valid,
        input  g_data,
        output g_ready
    );
endinterface

// File: rtl/beta_acs_engine.sv
// ---------------------------------------------------------------------------
// beta_acs_engine
// Backward-recursion (beta) unit of an 8-state MAP decoder. Consumes one
// gamma vector per trellis step (last step first), runs a normalised,
// saturating add-compare-select and stores every beta vector beta_0..beta_K
// in an internal buffer readable through a registered read port.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start_i          one-cycle block start request (honoured only when idle)
//   blk_len_i        block length K, legal range 1..K_MAX
//   term_mode_i      1 = terminated init vector, 0 = all-zero init vector
//   g_if             gamma stream (slave side)
//   busy_o           block in progress (INIT and RUN)
//   done_o           one-cycle pulse once beta_0 is written
//   err_o            one-cycle pulse after a start with illegal blk_len_i
//   sat_flag_o       sticky saturation flag, cleared by an accepted start
//   rd_en_i/rd_addr_i  buffer read request
//   rd_valid_o/rd_data_o  read response one cycle later, slice s = beta_k(s)
// ---------------------------------------------------------------------------
module beta_acs_engine #(
    parameter int W     = 16,
    parameter int GW    = 16,
    parameter int K_MAX = 256,
    parameter int AW    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [AW-1:0]        blk_len_i,
    input  logic                 term_mode_i,
    beta_acs_engine_if.slave     g_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 sat_flag_o,
    input  logic                 rd_en_i,
    input  logic [AW-1:0]        rd_addr_i,
    output logic                 rd_valid_o,
    output logic [8*W-1:0]       rd_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [W-1:0]  MIN_V  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  MAX_V  = {1'b0, {(W-1){1'b1}}};
    localparam logic [AW-1:0] KMAX_A = AW'(K_MAX);

    // Sign-extend a beta metric by one bit so sums cannot wrap.
    function automatic logic signed [W:0] ext_beta(input logic [W-1:0] x);
        return {x[W-1], x};
    endfunction

    // Sign-extend a gamma to the W+1 bit ACS width.
    function automatic logic signed [W:0] ext_gamma(input logic [GW-1:0] x);
        return {{(W+1-GW){x[GW-1]}}, x};
    endfunction

    // Overflow of a W+1 bit value relative to the W bit range.
    function automatic logic ovf_w(input logic [W:0] x);
        return x[W] ^ x[W-1];
    endfunction

    // Clamp a W+1 bit value into the signed W bit range.
    function automatic logic signed [W-1:0] sat_w(input logic [W:0] x);
        logic [W-1:0] r;
        if (ovf_w(x)) begin
            r = x[W] ? MIN_V : MAX_V;
        end else begin
            r = x[W-1:0];
        end
        return r;
    endfunction

    // Trellis successor nxt(s,u).
    function automatic logic [2:0] nxt(input logic [2:0] s, input logic u);
        logic [2:0] n;
        case (s)
            3'd0:    n = u ? 3'd4 : 3'd0;
            3'd1:    n = u ? 3'd0 : 3'd4;
            3'd2:    n = u ? 3'd1 : 3'd5;
            3'd3:    n = u ? 3'd5 : 3'd1;
            3'd4:    n = u ? 3'd6 : 3'd2;
            3'd5:    n = u ? 3'd2 : 3'd6;
            3'd6:    n = u ? 3'd3 : 3'd7;
            3'd7:    n = u ? 3'd7 : 3'd3;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    state_t             state_q, state_d;
    logic [AW-1:0]      len_q, len_d;
    logic [AW-1:0]      k_q, k_d;
    logic               term_q, term_d;
    logic [8*W-1:0]     beta_q, beta_d;
    logic               sat_q, sat_d;
    logic               err_q, err_d;
    logic               busy_q, done_q, g_ready_q;
    logic               rd_valid_q;
    logic [8*W-1:0]     rd_data_q;

    logic [8*W-1:0]     mem [0:K_MAX];

    logic signed [W:0]   sum0_s [8];
    logic signed [W:0]   sum1_s [8];
    logic signed [W:0]   diff_s [8];
    logic signed [W-1:0] c0_s   [8];
    logic signed [W-1:0] c1_s   [8];
    logic signed [W-1:0] best_s [8];
    logic [8*W-1:0]      beta_new_s;
    logic                acs_sat_s;
    logic [8*W-1:0]      init_vec_s;
    logic                hs_s;
    logic                wr_en_s;
    logic [AW-1:0]       wr_addr_s;
    logic [8*W-1:0]      wr_data_s;

    assign hs_s       = g_if.g_valid & g_ready_q;
    // Terminated trellis starts in state 0 only; all other states are -INF.
    assign init_vec_s = term_q ? {{7{MIN_V}}, {W{1'b0}}} : {(8*W){1'b0}};

    // Add-compare-select followed by normalisation against state 0.
    always_comb begin
        sum0_s     = '{default: '0};
        sum1_s     = '{default: '0};
        diff_s     = '{default: '0};
        c0_s       = '{default: '0};
        c1_s       = '{default: '0};
        best_s     = '{default: '0};
        beta_new_s = '0;
        acs_sat_s  = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sum0_s[s] = ext_beta(beta_q[nxt(3'(s), 1'b0)*W +: W])
                      + ext_gamma(g_if.g_data[(2*s)*GW +: GW]);
            sum1_s[s] = ext_beta(beta_q[nxt(3'(s), 1'b1)*W +: W])
                      + ext_gamma(g_if.g_data[(2*s+1)*GW +: GW]);
            c0_s[s]   = sat_w(sum0_s[s]);
            c1_s[s]   = sat_w(sum1_s[s]);
            // Ties resolve to the u=0 branch.
            best_s[s] = (c0_s[s] >= c1_s[s]) ? c0_s[s] : c1_s[s];
            acs_sat_s = acs_sat_s | ovf_w(sum0_s[s]) | ovf_w(sum1_s[s]);
        end
        for (int s = 0; s < 8; s++) begin
            diff_s[s] = ext_beta(best_s[s]) - ext_beta(best_s[0]);
            beta_new_s[s*W +: W] = sat_w(diff_s[s]);
            acs_sat_s = acs_sat_s | ovf_w(diff_s[s]);
        end
    end

    // Control FSM next-state, buffer write port and datapath register loads.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        k_d       = k_q;
        term_d    = term_q;
        beta_d    = beta_q;
        sat_d     = sat_q;
        err_d     = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = k_q;
        wr_data_s = beta_new_s;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if ((blk_len_i != {AW{1'b0}}) && (blk_len_i <= KMAX_A)) begin
                        len_d   = blk_len_i;
                        term_d  = term_mode_i;
                        sat_d   = 1'b0;
                        state_d = ST_INIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                wr_en_s   = 1'b1;
                wr_addr_s = len_q;
                wr_data_s = init_vec_s;
                beta_d    = init_vec_s;
                k_d       = len_q - {{(AW-1){1'b0}}, 1'b1};
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (hs_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = k_q;
                    wr_data_s = beta_new_s;
                    beta_d    = beta_new_s;
                    sat_d     = sat_q | acs_sat_s;
                    if (k_q == {AW{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d = k_q - {{(AW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            k_q       <= '0;
            term_q    <= 1'b0;
            beta_q    <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            g_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            k_q       <= k_d;
            term_q    <= term_d;
            beta_q    <= beta_d;
            sat_q     <= sat_d;
            err_q     <= err_d;
            busy_q    <= (state_d == ST_INIT) || (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
            g_ready_q <= (state_d == ST_RUN);
        end
    end

    // Beta buffer write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= wr_data_s;
        end
    end

    // Registered read port; reads see the pre-write contents on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= (rd_addr_i <= KMAX_A) ? mem[rd_addr_i] : {(8*W){1'b0}};
            end
        end
    end

    assign g_if.g_ready = g_ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign sat_flag_o   = sat_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;

endmodule

// File: tb/tb_beta_acs_engine.sv
// ---------------------------------------------------------------------------
// tb_beta_acs_engine
// Directed bench for beta_acs_engine: a table of single-step blocks with
// hand-computed beta vectors, then hand-written sequences for stalls,
// illegal starts, start during a block, sticky saturation and reset abort.
// Longer blocks are checked against a small integer reference model.
// ---------------------------------------------------------------------------
module tb_beta_acs_engine;
    localparam int W = 16, GW = 16, K_MAX = 256, AW = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   blk_len;
    logic            term_mode;
    logic            busy, done, err, sat_flag;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic            rd_valid;
    logic [8*W-1:0]  rd_data;

    beta_acs_engine_if #(.GW(GW)) gif ();

    beta_acs_engine #(.W(W), .GW(GW), .K_MAX(K_MAX), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .blk_len_i  (blk_len),
        .term_mode_i(term_mode),
        .g_if       (gif.slave),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .sat_flag_o (sat_flag),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           term;
        logic [255:0]   g;
        logic [127:0]   e1;
        logic [127:0]   e0;
        logic           es;
    } vec_t;

    vec_t          vt [5];
    logic [255:0]  gam [0:15];
    int            mb [0:8][0:7];
    bit            msat;
    int            n_chk = 0;
    int            n_fail = 0;
    int            nx0 [8] = '{0, 4, 5, 1, 2, 6, 7, 3};
    int            nx1 [8] = '{4, 0, 1, 5, 6, 2, 3, 7};

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] setg(input logic [255:0] v, input int s, input int u, input int val);
        logic [255:0] r;
        r = v;
        r[(2*s+u)*GW +: GW] = val[15:0];
        return r;
    endfunction

    function automatic logic [127:0] sete(input logic [127:0] v, input int s, input int val);
        logic [127:0] r;
        r = v;
        r[s*W +: W] = val[15:0];
        return r;
    endfunction

    function automatic int clampf(input int v);
        if (v > 32767) begin msat = 1'b1; return 32767; end
        if (v < -32768) begin msat = 1'b1; return -32768; end
        return v;
    endfunction

    function automatic int gget(input int idx, input int s, input int u);
        logic signed [15:0] x;
        x = gam[idx][(2*s+u)*GW +: GW];
        return int'(x);
    endfunction

    // Reference model: gam[idx] is the vector for step k = len-1-idx.
    task automatic model_block(input logic term, input int len);
        int c0, c1, cb [8];
        msat = 1'b0;
        for (int s = 0; s < 8; s++) mb[len][s] = (term && s != 0) ? -32768 : 0;
        for (int idx = 0; idx < len; idx++) begin
            for (int s = 0; s < 8; s++) begin
                c0 = clampf(mb[len-idx][nx0[s]] + gget(idx, s, 0));
                c1 = clampf(mb[len-idx][nx1[s]] + gget(idx, s, 1));
                cb[s] = (c0 >= c1) ? c0 : c1;
            end
            for (int s = 0; s < 8; s++) mb[len-1-idx][s] = clampf(cb[s] - cb[0]);
        end
    endtask

    task automatic rd(input int a, output logic [127:0] d);
        rd_en = 1'b1;
        rd_addr = a[AW-1:0];
        tick();
        rd_en = 1'b0;
        check("rd_valid", rd_valid, 1'b1);
        d = rd_data;
    endtask

    task automatic cmp_block(input string tag, input int len);
        logic [127:0] d, e;
        for (int k = 0; k <= len; k++) begin
            e = '0;
            for (int s = 0; s < 8; s++) e = sete(e, s, mb[k][s]);
            rd(k, d);
            check($sformatf("%s_beta%0d", tag, k), d, e);
        end
    endtask

    // Runs one block from gam[]; optional stall of stall_n cycles once
    // stall_at vectors are accepted, optional illegal start poked at poke_cyc.
    task automatic run_block(input logic term, input int len, input int stall_at, input int stall_n,
                             input int poke_cyc, output int cyc, output bit err_seen, output bit stall_bad);
        int  idx = 0, st = 0;
        bit  hs, seen = 1'b0;
        cyc = 0; err_seen = 1'b0; stall_bad = 1'b0;
        start = 1'b1; blk_len = len[AW-1:0]; term_mode = term;
        while (!seen && cyc < 200) begin
            if (cyc == poke_cyc) begin start = 1'b1; blk_len = '0; end
            if (idx == stall_at && st < stall_n) begin
                gif.g_valid = 1'b0;
                st++;
                if (!gif.g_ready) stall_bad = 1'b1;
            end else if (idx < len) begin
                gif.g_valid = 1'b1;
                gif.g_data = gam[idx];
            end else begin
                gif.g_valid = 1'b0;
            end
            hs = gif.g_valid && gif.g_ready;
            tick();
            cyc++;
            start = 1'b0;
            if (hs) idx++;
            if (err) err_seen = 1'b1;
            if (done) seen = 1'b1;
        end
        gif.g_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        bit es, sb;
        logic [127:0] d, e;
        logic [255:0] g;

        // ---- stimulus table: single-step blocks, hand-computed results ----
        for (int i = 0; i < 5; i++) begin
            vt[i].g = '0; vt[i].e1 = '0; vt[i].e0 = '0; vt[i].es = 1'b0; vt[i].term = 1'b0;
        end
        // terminated, zero gammas
        vt[0].term = 1'b1;
        for (int s = 1; s < 8; s++) vt[0].e1 = sete(vt[0].e1, s, -32768);
        for (int s = 2; s < 8; s++) vt[0].e0 = sete(vt[0].e0, s, -32768);
        // unterminated, g(s,0) = 4s
        for (int s = 0; s < 8; s++) begin
            vt[1].g  = setg(vt[1].g, s, 0, 4*s);
            vt[1].e0 = sete(vt[1].e0, s, 4*s);
        end
        // saturating normalisation
        vt[2].g = setg(setg(vt[2].g, 0, 0, -32768), 0, 1, -32768);
        vt[2].g = setg(setg(vt[2].g, 1, 0, 32767), 1, 1, 32767);
        for (int s = 1; s < 8; s++) vt[2].e0 = sete(vt[2].e0, s, 32767);
        vt[2].es = 1'b1;
        // all-negative gammas: g(s,u) = -(s+1)*100 - u
        for (int s = 0; s < 8; s++) begin
            vt[3].g  = setg(setg(vt[3].g, s, 0, -(s+1)*100), s, 1, -(s+1)*100 - 1);
            vt[3].e0 = sete(vt[3].e0, s, -100*s);
        end
        // terminated, g(s,u) = 10s + u
        vt[4].term = 1'b1;
        for (int s = 0; s < 8; s++) vt[4].g = setg(setg(vt[4].g, s, 0, 10*s), s, 1, 10*s + 1);
        for (int s = 1; s < 8; s++) vt[4].e1 = sete(vt[4].e1, s, -32768);
        vt[4].e0 = sete(vt[4].e0, 1, 11);
        for (int s = 2; s < 8; s++) vt[4].e0 = sete(vt[4].e0, s, -32768 + 10*s + 1);

        // ---- reset state ----
        rst = 1'b1; start = 1'b0; blk_len = '0; term_mode = 1'b0;
        rd_en = 1'b0; rd_addr = '0; gif.g_valid = 1'b0; gif.g_data = '0;
        tick(); tick();
        check("reset_status", {busy, done, err, gif.g_ready, sat_flag, rd_valid}, 6'b0);
        check("reset_rd_data", rd_data, 128'b0);
        rst = 1'b0;
        tick();

        // ---- table-driven single-step blocks ----
        for (int i = 0; i < 5; i++) begin
            gam[0] = vt[i].g;
            run_block(vt[i].term, 1, -1, 0, -1, cyc, es, sb);
            check($sformatf("v%0d_done_cycles", i), cyc, 3);
            rd(1, d);
            check($sformatf("v%0d_addr1", i), d, vt[i].e1);
            rd(0, d);
            check($sformatf("v%0d_addr0", i), d, vt[i].e0);
            check($sformatf("v%0d_sat", i), sat_flag, vt[i].es);
        end

        // ---- sticky saturation, cleared by next accepted start ----
        gam[0] = vt[2].g;
        run_block(1'b0, 1, -1, 0, -1, cyc, es, sb);
        repeat (5) tick();
        check("sat_sticky", sat_flag, 1'b1);
        start = 1'b1; blk_len = 9'd1; term_mode = 1'b0;
        tick();
        start = 1'b0;
        check("sat_cleared_on_start", sat_flag, 1'b0);
        check("busy_in_init", busy, 1'b1);
        gif.g_valid = 1'b1; gif.g_data = '0;
        tick(); tick();
        gif.g_valid = 1'b0;
        check("done_after_manual", {done, busy}, 2'b10);
        tick();
        check("done_one_cycle", done, 1'b0);

        // ---- K=4 without and with a 3-cycle stall ----
        for (int idx = 0; idx < 4; idx++) begin
            g = '0;
            for (int s = 0; s < 8; s++)
                for (int u = 0; u < 2; u++)
                    g = setg(g, s, u, (((s*3 + u*5 + idx*7) % 11) - 5) * 3000);
            gam[idx] = g;
        end
        model_block(1'b1, 4);
        run_block(1'b1, 4, -1, 0, -1, cyc, es, sb);
        check("k4_done_cycles", cyc, 6);
        check("k4_sat", sat_flag, msat);
        cmp_block("k4", 4);
        run_block(1'b1, 4, 2, 3, -1, cyc, es, sb);
        check("k4stall_done_cycles", cyc, 9);
        check("k4stall_ready_held", sb, 1'b0);
        cmp_block("k4stall", 4);

        // ---- out-of-range read returns zero ----
        rd(300, d);
        check("rd_out_of_range", d, 128'b0);

        // ---- illegal block lengths ----
        start = 1'b1; blk_len = 9'd0;
        tick();
        start = 1'b0;
        check("err_len0", {err, busy}, 2'b10);
        tick();
        check("err_len0_pulse", err, 1'b0);
        start = 1'b1; blk_len = 9'd257;
        tick();
        start = 1'b0;
        check("err_len257", {err, busy}, 2'b10);
        tick();
        check("err_len257_pulse", {err, busy}, 2'b00);

        // ---- start during RUN is ignored ----
        for (int idx = 0; idx < 8; idx++) begin
            g = '0;
            for (int s = 0; s < 8; s++)
                for (int u = 0; u < 2; u++)
                    g = setg(g, s, u, ((s*13 + u*29 + idx*31) % 17) * 50 - 400);
            gam[idx] = g;
        end
        model_block(1'b0, 2);
        run_block(1'b0, 2, -1, 0, 2, cyc, es, sb);
        check("busy_start_done_cycles", cyc, 4);
        check("busy_start_no_err", es, 1'b0);
        cmp_block("busy_start", 2);

        // ---- reset mid-RUN at K=8 ----
        start = 1'b1; blk_len = 9'd8; term_mode = 1'b0;
        tick();
        start = 1'b0;
        gif.g_valid = 1'b1; gif.g_data = gam[0];
        repeat (4) tick();
        rd_en = 1'b1; rd_addr = 9'd1;
        check("k8_busy_before_rst", {busy, gif.g_ready}, 2'b11);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_status", {busy, done, err, gif.g_ready, sat_flag, rd_valid}, 6'b0);
        check("rst_mid_rd_data", rd_data, 128'b0);
        gif.g_valid = 1'b0; rd_en = 1'b0;
        tick();
        rst = 1'b0;
        es = 1'b0;
        repeat (12) begin
            tick();
            if (done || busy) es = 1'b1;
        end
        check("rst_no_done", es, 1'b0);
        run_block(1'b0, 2, -1, 0, -1, cyc, es, sb);
        check("post_rst_done_cycles", cyc, 4);
        cmp_block("post_rst", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
